// File: rtl/decode_ctrl.sv
// IF/ID pipeline register plus front-end hazard control: jump redirect, load-use
// stall and a one-deep ID/EX tracking register handed to execute.
module decode_ctrl #(
  parameter logic [31:0] NOP   = 32'h0000_0000,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instruction_Code,
  input  logic [31:0]      PC,
  output logic             jump,
  output logic [31:0]      extended,
  output logic             stall,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic             id_valid,
  output logic [31:0]      ex_instr,
  output logic             ex_valid,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [31:0]      r_id_instr;
  logic [31:0]      r_id_pc;
  logic             r_id_valid;
  logic [31:0]      r_ex_instr;
  logic             r_ex_valid;
  logic [CNT_W-1:0] r_stall_cycles;

  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_ex_rt;
  logic       w_is_j;
  logic       w_ex_load;
  logic       w_uses_rt;
  logic       w_stall;
  logic       w_pc_carry;
  logic [3:0] w_pc_hi;

  assign w_op    = r_id_instr[31:26];
  assign w_rs    = r_id_instr[25:21];
  assign w_rt    = r_id_instr[20:16];
  assign w_ex_rt = r_ex_instr[20:16];

  assign w_is_j    = r_id_valid & ((w_op == 6'b000010) | (w_op == 6'b000011));
  assign w_ex_load = r_ex_valid & (r_ex_instr[31:26] == 6'b100011);
  assign w_uses_rt = (w_op == 6'b000000) | (w_op == 6'b000100) |
                     (w_op == 6'b000101) | (w_op == 6'b101011);
  assign w_stall   = r_id_valid & ~w_is_j & w_ex_load & (w_ex_rt != 5'd0) &
                     ((w_ex_rt == w_rs) | (w_uses_rt & (w_ex_rt == w_rt)));

  // Upper nibble of id_pc+4: bits [1:0] never carry, so only [27:2] all-ones wraps into [31:28].
  assign w_pc_carry = &r_id_pc[27:2];
  assign w_pc_hi    = r_id_pc[31:28] + {3'b000, w_pc_carry};

  assign jump     = w_is_j;
  assign stall    = w_stall;
  assign extended = w_is_j ? {w_pc_hi, r_id_instr[25:0], 2'b00} : 32'h0000_0000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_id_instr     <= NOP;
      r_id_pc        <= 32'h0000_0000;
      r_id_valid     <= 1'b0;
      r_ex_instr     <= NOP;
      r_ex_valid     <= 1'b0;
      r_stall_cycles <= '0;
    end else if (w_stall) begin
      // IF/ID holds the dependent instruction; a bubble goes down to execute.
      r_ex_instr <= NOP;
      r_ex_valid <= 1'b0;
      if (r_stall_cycles != {CNT_W{1'b1}}) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end else if (w_is_j) begin
      r_ex_instr <= r_id_instr;
      r_ex_valid <= 1'b1;
      r_id_instr <= NOP;
      r_id_pc    <= 32'h0000_0000;
      r_id_valid <= 1'b0;
    end else begin
      r_ex_instr <= r_id_instr;
      r_ex_valid <= r_id_valid;
      r_id_instr <= Instruction_Code;
      r_id_pc    <= PC;
      r_id_valid <= 1'b1;
    end
  end

  assign id_instr     = r_id_instr;
  assign id_pc        = r_id_pc;
  assign id_valid     = r_id_valid;
  assign ex_instr     = r_ex_instr;
  assign ex_valid     = r_ex_valid;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: a small fetch model feeds the DUT, a behavioural pipeline
// model is compared every cycle, and literal expectations pin key timing points.
module tb_decode_ctrl;

  localparam logic [31:0] LW2    = 32'h8C22_0000;  // lw $2,0($1)
  localparam logic [31:0] ADD2   = 32'h0044_1820;  // add $3,$2,$4
  localparam logic [31:0] LW0    = 32'h8C20_0000;  // lw $0,0($1)
  localparam logic [31:0] ADD0   = 32'h0004_1820;  // add $3,$0,$4
  localparam logic [31:0] ADDI   = 32'h20C5_0001;  // addi $5,$6,1
  localparam logic [31:0] JWORD  = 32'h0800_0040;  // j 0x100
  localparam logic [31:0] SEQ    = 32'h2000_0014;
  localparam logic [31:0] TGT    = 32'h2001_0100;

  logic        clk;
  logic        reset;
  logic [31:0] Instruction_Code;
  logic [31:0] PC;

  logic        jump, stall, id_valid, ex_valid;
  logic [31:0] extended, id_instr, id_pc, ex_instr;
  logic [15:0] stall_cycles;

  logic        b_jump, b_stall, b_id_valid, b_ex_valid;
  logic [31:0] b_extended, b_id_instr, b_id_pc, b_ex_instr;
  logic [1:0]  b_stall_cycles;

  decode_ctrl dut (
    .clk(clk), .reset(reset), .Instruction_Code(Instruction_Code), .PC(PC),
    .jump(jump), .extended(extended), .stall(stall), .id_instr(id_instr),
    .id_pc(id_pc), .id_valid(id_valid), .ex_instr(ex_instr), .ex_valid(ex_valid),
    .stall_cycles(stall_cycles)
  );

  decode_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .Instruction_Code(Instruction_Code), .PC(PC),
    .jump(b_jump), .extended(b_extended), .stall(b_stall), .id_instr(b_id_instr),
    .id_pc(b_id_pc), .id_valid(b_id_valid), .ex_instr(b_ex_instr), .ex_valid(b_ex_valid),
    .stall_cycles(b_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Fetch model and program memory.
  logic [31:0] mem [256];
  logic [31:0] pc_reg;

  // Behavioural pipeline model.
  logic [31:0] m_id_i, m_id_pc, m_ex_i;
  logic        m_id_v, m_ex_v;
  int          m_cnt, m_cnt2;

  // Per-cycle history of DUT outputs, indexed by cycle since reset release.
  logic        h_stall [64];
  logic        h_jump  [64];
  logic        h_idv   [64];
  logic        h_exv   [64];
  logic [31:0] h_idi   [64];
  logic [31:0] h_idpc  [64];
  logic [31:0] h_exi   [64];
  logic [31:0] h_ext   [64];
  logic [1:0]  h_cnt2  [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_jump();
    logic [5:0] op;
    op = m_id_i[31:26];
    return m_id_v && (op == 6'd2 || op == 6'd3);
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] p4;
    p4 = m_id_pc + 32'd4;
    return m_jump() ? {p4[31:28], m_id_i[25:0], 2'b00} : 32'd0;
  endfunction

  function automatic logic m_stall();
    logic [5:0] op;
    logic [4:0] lrt;
    logic       rt_used, lw_in_ex;
    op       = m_id_i[31:26];
    lrt      = m_ex_i[20:16];
    lw_in_ex = m_ex_v && (m_ex_i[31:26] == 6'h23);
    rt_used  = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    if (!m_id_v || m_jump() || !lw_in_ex || lrt == 5'd0) return 1'b0;
    return (lrt == m_id_i[25:21]) || (rt_used && lrt == m_id_i[20:16]);
  endfunction

  task automatic model_reset();
    m_id_i = 32'd0; m_id_pc = 32'd0; m_id_v = 1'b0;
    m_ex_i = 32'd0; m_ex_v = 1'b0;
    m_cnt = 0; m_cnt2 = 0;
    pc_reg = 32'd0;
  endtask

  task automatic load_prog(input logic [31:0] words [], input logic [31:0] base);
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    for (int i = 0; i < words.size(); i++) mem[(base >> 2) + i] = words[i];
  endtask

  task automatic check_cycle(input int c);
    chk("jump", {31'd0, jump}, {31'd0, m_jump()});
    chk("extended", extended, m_target());
    chk("stall", {31'd0, stall}, {31'd0, m_stall()});
    chk("id_instr", id_instr, m_id_i);
    chk("id_pc", id_pc, m_id_pc);
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_id_v});
    chk("ex_instr", ex_instr, m_ex_i);
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex_v});
    chk("stall_cycles", {16'd0, stall_cycles}, m_cnt);
    chk("stall_cycles_w2", {30'd0, b_stall_cycles}, m_cnt2);
    chk("stall_w2", {31'd0, b_stall}, {31'd0, m_stall()});
    h_stall[c] = stall; h_jump[c] = jump; h_idv[c] = id_valid; h_exv[c] = ex_valid;
    h_idi[c] = id_instr; h_idpc[c] = id_pc; h_exi[c] = ex_instr; h_ext[c] = extended;
    h_cnt2[c] = b_stall_cycles;
    $display("cyc %0d pc=%h id=%h/%h v=%0d ex=%h v=%0d j=%0d st=%0d cnt=%0d",
             c, PC, id_pc, id_instr, id_valid, ex_instr, ex_valid, jump, stall, stall_cycles);
  endtask

  task automatic drive_and_step();
    logic        s, j;
    logic [31:0] t;
    s = m_stall(); j = m_jump(); t = m_target();
    PC = pc_reg;
    Instruction_Code = mem[pc_reg[9:2]];
    if (s) begin
      m_ex_i = 32'd0; m_ex_v = 1'b0;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else if (j) begin
      m_ex_i = m_id_i; m_ex_v = 1'b1;
      m_id_i = 32'd0; m_id_pc = 32'd0; m_id_v = 1'b0;
    end else begin
      m_ex_i = m_id_i; m_ex_v = m_id_v;
      m_id_i = Instruction_Code; m_id_pc = PC; m_id_v = 1'b1;
    end
    pc_reg = s ? pc_reg : (j ? t : pc_reg + 32'd4);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      check_cycle(c);
      drive_and_step();
      @(negedge clk);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_jump"}, {31'd0, jump}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_extended"}, extended, 32'd0);
    chk({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, "_ex_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_id_instr"}, id_instr, 32'd0);
    chk({tag, "_id_pc"}, id_pc, 32'd0);
    chk({tag, "_ex_instr"}, ex_instr, 32'd0);
    chk({tag, "_cnt"}, {16'd0, stall_cycles}, 32'd0);
    chk({tag, "_cnt_w2"}, {30'd0, b_stall_cycles}, 32'd0);
  endtask

  // Enters reset at a negedge, exercises random inputs with the clock running, releases at a negedge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      Instruction_Code = $urandom();
      PC = $urandom();
      @(negedge clk);
      check_cleared(tag);
    end
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] prog [];
    int          n;
    reset = 1'b1;
    Instruction_Code = 32'd0;
    PC = 32'd0;
    model_reset();
    @(negedge clk);

    // Reset with random inputs.
    do_reset("reset");

    // Load-use: exactly one stall, bubble, add reaches ex one cycle late.
    prog = new[2]; prog[0] = LW2; prog[1] = ADD2;
    load_prog(prog, 32'h0);
    run(8);
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(h_stall[i]);
    chk("lu_stall_total", n, 1);
    chk("lu_stall_c2", {31'd0, h_stall[2]}, 32'd1);
    chk("lu_exv_c3", {31'd0, h_exv[3]}, 32'd0);
    chk("lu_add_in_ex_c4", h_exi[4], ADD2);
    chk("lu_add_still_id_c3", h_idi[3], ADD2);
    chk("lu_count", {16'd0, stall_cycles}, 32'd1);

    // No false hazard: lw $0 then add using $0.
    do_reset("reset2");
    prog = new[2]; prog[0] = LW0; prog[1] = ADD0;
    load_prog(prog, 32'h0);
    run(6);
    n = 0;
    for (int i = 0; i < 6; i++) n += int'(h_stall[i]);
    chk("nf_zero_stall", n, 0);

    // No false hazard: lw $2 then addi with rt unused.
    do_reset("reset3");
    prog = new[2]; prog[0] = LW2; prog[1] = ADDI;
    load_prog(prog, 32'h0);
    run(6);
    n = 0;
    for (int i = 0; i < 6; i++) n += int'(h_stall[i]);
    chk("nf_addi_stall", n, 0);

    // Jump at 0x10 to 0x100.
    do_reset("reset4");
    prog = new[6];
    prog[0] = 0; prog[1] = 0; prog[2] = 0; prog[3] = 0; prog[4] = JWORD; prog[5] = SEQ;
    load_prog(prog, 32'h0);
    mem[32'h100 >> 2] = TGT;
    run(10);
    chk("j_jump_c5", {31'd0, h_jump[5]}, 32'd1);
    chk("j_ext_c5", h_ext[5], 32'h0000_0100);
    chk("j_idpc_c5", h_idpc[5], 32'h0000_0010);
    chk("j_jump_c6", {31'd0, h_jump[6]}, 32'd0);
    chk("j_idv_c6", {31'd0, h_idv[6]}, 32'd0);
    chk("j_exi_c6", h_exi[6], JWORD);
    chk("j_tgt_c7", h_idi[7], TGT);
    chk("j_tgtpc_c7", h_idpc[7], 32'h0000_0100);

    // Reset asserted during the load-use stall cycle.
    do_reset("reset5");
    prog = new[2]; prog[0] = LW2; prog[1] = ADD2;
    load_prog(prog, 32'h0);
    run(2);
    check_cycle(2);
    chk("ms_in_stall", {31'd0, stall}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_cleared("ms_async");
    do_reset("ms_hold");
    run(3);
    chk("ms_resume_idi", h_idi[1], LW2);
    chk("ms_resume_idv", {31'd0, h_idv[1]}, 32'd1);
    chk("ms_resume_stall", {31'd0, h_stall[2]}, 32'd1);

    // Counter saturation with five load-use pairs.
    do_reset("reset6");
    prog = new[10];
    for (int i = 0; i < 5; i++) begin
      prog[2*i] = LW2; prog[2*i+1] = ADD2;
    end
    load_prog(prog, 32'h0);
    run(20);
    n = 0;
    for (int i = 0; i < 20; i++) n += int'(h_stall[i]);
    chk("sat_stalls", n, 5);
    chk("sat_cnt16", {16'd0, stall_cycles}, 32'd5);
    chk("sat_cnt2", {30'd0, b_stall_cycles}, 32'd3);
    chk("sat_cnt2_mid", {30'd0, h_cnt2[19]}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
